// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch (I) and data (D) ports of rv_cpu.
// One transaction outstanding at a time; D wins unless I has waited through MAX_D_STREAK D grants.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic                CLK,
    input  logic                RST,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_flush,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {StIdle, StIBusy, StDBusy} state_e;

    state_e              state;
    logic                drop;
    logic [STREAK_W-1:0] streak;
    logic                grant_d;
    logic                grant_i;

    // I is forced only when it is actually waiting and D has used up its streak.
    always_comb begin
        grant_d = d_req && !(i_req && (streak == STREAK_MAX));
        grant_i = !grant_d && i_req;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= StIdle;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            drop      <= 1'b0;
            streak    <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (grant_d) begin
                        state     <= StDBusy;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wstrb <= d_wstrb;
                        if (!i_req) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + STREAK_W'(1);
                        end
                    end else if (grant_i) begin
                        state     <= StIBusy;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                        mem_wstrb <= {STRB_W{1'b0}};
                        streak    <= '0;
                    end
                end
                StIBusy: begin
                    // A flushed fetch still has to finish on the memory side; only its ack is hidden.
                    if (mem_ack) begin
                        state   <= StIdle;
                        mem_req <= 1'b0;
                        drop    <= 1'b0;
                    end else if (i_flush) begin
                        drop <= 1'b1;
                    end
                end
                StDBusy: begin
                    if (mem_ack) begin
                        state   <= StIdle;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= StIdle;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = (state != StIdle);
    assign d_ack   = (state == StDBusy) && mem_ack;
    assign i_ack   = (state == StIBusy) && mem_ack && !drop && !i_flush;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between instruction fetch (I port) and data access (D port) of the rv_cpu pipeline.
- Serialises requests, with one transaction outstanding at a time.
- D has priority, bounded by an anti-starvation streak counter.
- Handles control-hazard flushes by discarding the response of an in-flight fetch.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- MAX_D_STREAK, 4, consecutive D grants allowed while I is waiting before I is forced; must be ≥1.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  ADDR_W  fetch address; stable while i_req is high.
- i_flush  in  1  one-cycle pulse; discard any in-flight fetch.
- i_ack  out  1  fetch complete; i_rdata valid.
- i_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_wstrb  in  DATA_W/8  byte enables.
- d_ack  out  1  data access complete.
- d_rdata  out  DATA_W  read data; meaningful only for reads.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wstrb  out  DATA_W/8  memory byte enables.
- mem_ack  in  1  memory response; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: RST low clears, asynchronously, every registered output and internal state:
  - state = IDLE, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_wstrb = 0.
  - drop = 0, streak = 0.
  - i_ack, d_ack and busy are 0. i_rdata and d_rdata are don't-care.
- FSM states: IDLE, IBUSY, DBUSY.
- Grant (evaluated in IDLE only):
  - d_req & !(i_req & streak == MAX_D_STREAK): grant D.
  - Otherwise, if i_req: grant I.
  - Otherwise: stay in IDLE.
- On grant, at the next edge:
  - state becomes IBUSY or DBUSY.
  - mem_req = 1 and mem_* fields are registered from the granted port.
  - For I grants: mem_we = 0, mem_wstrb = 0, mem_wdata = 0.
- Busy states:
  - mem_req and all mem_* fields are held constant until mem_ack.
  - mem_ack may arrive in the first cycle mem_req is high (zero wait states) or any later cycle.
- Completion (combinational in the mem_ack cycle):
  - DBUSY: d_ack = mem_ack.
  - IBUSY: i_ack = mem_ack & !drop & !i_flush.
  - i_rdata = d_rdata = mem_rdata pass-through.
- On the mem_ack edge:
  - state becomes IDLE, mem_req = 0, drop = 0.
  - No back-to-back grant in the same edge; IDLE always occupies one cycle.
  - Minimum latency is 2 cycles from req seen in IDLE to ack (grant cycle, then ack cycle).
- Requester protocol:
  - A requester may deassert or change req at the edge where it sampled its ack.
  - Requesters never drop req before ack, except the I port after i_flush.
- Flush:
  - i_flush in IBUSY sets drop; the pending mem_ack completes the memory transaction silently (no i_ack).
  - i_flush coincident with mem_ack in IBUSY also suppresses i_ack.
  - i_flush in IDLE or DBUSY has no effect.
  - While drop = 1, i_req / i_addr may change freely; the new request is arbitrated in IDLE.
- Streak counter (width $clog2(MAX_D_STREAK+1)):
  - On a D grant with i_req = 1: increment, saturating at MAX_D_STREAK.
  - On a D grant with i_req = 0: clear.
  - On any I grant: clear.
- Stray inputs:
  - mem_ack in IDLE is ignored.
  - Reset mid-transaction abandons it; any later mem_ack is ignored.
- Simultaneous requests: d_req & i_req in IDLE with streak < MAX_D_STREAK gives D.

Test Plan:
- Single fetch: i_req = 1, i_addr = 0x100, mem_ack after 0 waits with rdata 0x00500093 -> mem_req high for exactly 1 cycle with mem_addr = 0x100 and mem_we = 0; i_ack for 1 cycle with i_rdata = 0x00500093.
- Priority: i_req and d_req raised together, d_we = 1, d_addr = 0x2000, d_wdata = 0xDEADBEEF, d_wstrb = 0xF -> D served first with mem_we = 1 and matching fields, then IDLE, then I served.
- Starvation: i_req held high while d_req is re-asserted immediately after every d_ack -> exactly 4 D grants, then 1 I grant, then D again; streak reads 0 after the I grant.
- Flush: I granted at 0x40, mem_ack delayed 3 cycles, i_flush pulsed 1 cycle after grant -> no i_ack, state returns to IDLE after mem_ack, then the new i_addr 0x80 is granted and acked normally.
- Flush coincident with mem_ack -> i_ack stays 0.
- Async reset: RST low mid-DBUSY (off clock edge) -> mem_req = 0 and busy = 0 immediately; a mem_ack pulse afterwards produces no d_ack.
